// File: rtl/int_split_pkg.sv
// rtl/int_split_pkg.sv - shared types, defaults and sample arithmetic for int_split
package int_split_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_LOG2_N = 4;
  localparam int N          = 1 << DEF_LOG2_N;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Sample k of a burst: the quotient, plus one for the first 'rem' samples so the burst sums to the word.
  function automatic logic [31:0] split_sample(input logic [31:0] base,
                                               input logic [31:0] rem,
                                               input logic [31:0] k);
    return base + ((k < rem) ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/int_split_if.sv
// rtl/int_split_if.sv - word-in / sample-out handshake bundle for int_split
interface int_split_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  // Source of words and sink of samples
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // The splitter itself
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/int_split.sv
// rtl/int_split.sv - expands each word into a burst of 2**LOG2_N samples summing to the word
module int_split
  import int_split_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LOG2_N = DEF_LOG2_N
) (
  input  logic       clk,
  input  logic       rst,
  int_split_if.slave s
);

  localparam int BW = WIDTH - LOG2_N;
  localparam logic [LOG2_N-1:0] K_LAST = '1;

  // Active burst and one-entry pending word
  state_t            r_state;
  logic [BW-1:0]     r_base;
  logic [LOG2_N-1:0] r_rem;
  logic [LOG2_N-1:0] r_k;
  logic [WIDTH-1:0]  r_pend_data;
  logic              r_pend_full;

  // Registered outputs
  logic              r_in_ready;
  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  logic              r_out_last;

  // Next-state values
  state_t            w_state;
  logic [BW-1:0]     w_base;
  logic [LOG2_N-1:0] w_rem;
  logic [LOG2_N-1:0] w_k;
  logic [WIDTH-1:0]  w_pend_data;
  logic              w_pend_full;
  logic              w_out_fire;
  logic              w_in_fire;
  logic              w_burst_end;
  logic [WIDTH-1:0]  w_sample;

  // Decide where an accepted word goes and how the burst index moves
  always_comb begin
    w_out_fire  = (r_state == EMIT) && s.out_ready;
    w_in_fire   = s.in_valid && r_in_ready;
    w_burst_end = w_out_fire && (r_k == K_LAST);
    w_state     = r_state;
    w_base      = r_base;
    w_rem       = r_rem;
    w_k         = r_k;
    w_pend_data = r_pend_data;
    w_pend_full = r_pend_full;

    case (r_state)
      IDLE: begin
        if (w_in_fire) begin
          w_state = EMIT;
          w_base  = s.in_data[WIDTH-1:LOG2_N];
          w_rem   = s.in_data[LOG2_N-1:0];
          w_k     = '0;
        end
      end
      EMIT: begin
        if (w_burst_end) begin
          // Chain straight into the next burst when a word is waiting or arriving, so there is no bubble
          w_k = '0;
          if (r_pend_full) begin
            w_base      = r_pend_data[WIDTH-1:LOG2_N];
            w_rem       = r_pend_data[LOG2_N-1:0];
            w_pend_full = 1'b0;
          end else if (w_in_fire) begin
            w_base = s.in_data[WIDTH-1:LOG2_N];
            w_rem  = s.in_data[LOG2_N-1:0];
          end else begin
            w_state = IDLE;
          end
        end else begin
          if (w_out_fire) begin
            w_k = r_k + 1'b1;
          end
          if (w_in_fire) begin
            w_pend_data = s.in_data;
            w_pend_full = 1'b1;
          end
        end
      end
      default: w_state = IDLE;
    endcase

    w_sample = WIDTH'(split_sample(32'(w_base), 32'(w_rem), 32'(w_k)));
  end

  // State update; outputs are registered from next-state so they stay put during stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_rem       <= '0;
      r_k         <= '0;
      r_pend_data <= '0;
      r_pend_full <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_base      <= w_base;
      r_rem       <= w_rem;
      r_k         <= w_k;
      r_pend_data <= w_pend_data;
      r_pend_full <= w_pend_full;
      r_in_ready  <= !w_pend_full;
      r_out_valid <= (w_state == EMIT);
      r_out_data  <= (w_state == EMIT) ? w_sample : '0;
      r_out_last  <= (w_state == EMIT) && (w_k == K_LAST);
    end
  end

  assign s.in_ready  = r_in_ready;
  assign s.out_valid = r_out_valid;
  assign s.out_data  = r_out_data;
  assign s.out_last  = r_out_last;

endmodule
